// File: rtl/ps_pl_reg_pkg.sv
// Shared constants, channel state types and byte-strobe merge helper for the
// PS->PL AXI4-Lite register slave.
package ps_pl_reg_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned STRB_WIDTH = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_RESET,
        WR_IDLE,
        WR_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_RESET,
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    function automatic logic [DATA_WIDTH-1:0] strb_merge(
        input logic [DATA_WIDTH-1:0] cur,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [STRB_WIDTH-1:0] strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = cur;
        for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ps_pl_reg_bank.sv
// Control register storage with strobe merge, per-word write pulse and read mux.
// PS_PL_REG_STATUS_EN maps status_in onto word indices NUM_REGS..2*NUM_REGS-1.
module ps_pl_reg_bank
    import ps_pl_reg_pkg::*;
#(
    parameter int unsigned IDX_WIDTH = 3,
    parameter int unsigned NUM_REGS  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [IDX_WIDTH-1:0]         wr_idx,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [STRB_WIDTH-1:0]        wr_strb,
    output logic                         wr_ok,
    input  logic [IDX_WIDTH-1:0]         rd_idx,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_ok,
    input  logic [NUM_REGS*32-1:0]       status_in,
    output logic [NUM_REGS*32-1:0]       reg_out,
    output logic [NUM_REGS-1:0]          reg_wr_pulse
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [31:0]           wr_idx32;
    logic [31:0]           rd_idx32;

    always_comb begin
        wr_idx32 = 32'(wr_idx);
        rd_idx32 = 32'(rd_idx);
        wr_ok    = (wr_idx32 < NUM_REGS);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            reg_wr_pulse <= '0;
        end else begin
            reg_wr_pulse <= '0;
            if (wr_en && wr_ok) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (wr_idx32 == i) begin
                        regs_q[i]       <= strb_merge(regs_q[i], wr_data, wr_strb);
                        reg_wr_pulse[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        reg_out = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_out[32*i +: 32] = regs_q[i];
        end
    end

    always_comb begin
        rd_data = '0;
        rd_ok   = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_idx32 == i) begin
                rd_data = regs_q[i];
                rd_ok   = 1'b1;
            end
        end
`ifdef PS_PL_REG_STATUS_EN
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_idx32 == NUM_REGS + i) begin
                rd_data = status_in[32*i +: 32];
                rd_ok   = 1'b1;
            end
        end
`endif
    end

`ifndef PS_PL_REG_STATUS_EN
    logic unused_status;
    assign unused_status = ^status_in;
`endif

endmodule

// File: rtl/ps_pl_reg_slave.sv
// AXI4-Lite slave exposing PS->PL control registers; optional PL->PS status
// window enabled by PS_PL_REG_STATUS_EN (handled inside ps_pl_reg_bank).
module ps_pl_reg_slave
    import ps_pl_reg_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_REGS   = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]              S_AXI_AWPROT,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [31:0]             S_AXI_WDATA,
    input  logic [3:0]              S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]              S_AXI_ARPROT,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [31:0]             S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]  reg_out,
    output logic [NUM_REGS-1:0]     reg_wr_pulse,
    input  logic [NUM_REGS*32-1:0]  status_in
);

    localparam int unsigned IDX_WIDTH = ADDR_WIDTH - 2;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic                  aw_full, w_full;
    logic [IDX_WIDTH-1:0]  aw_idx;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  aw_hs, w_hs, ar_hs, commit, wr_ok;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_ok;

    // Write channel: buffers fill independently, commit waits for an idle B channel.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) wr_state <= WR_RESET;
        else          wr_state <= wr_next;
    end

    always_comb begin
        wr_next       = wr_state;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        commit        = 1'b0;
        case (wr_state)
            WR_RESET: wr_next = WR_IDLE;
            WR_IDLE: begin
                S_AXI_AWREADY = !aw_full;
                S_AXI_WREADY  = !w_full;
                if (aw_full && w_full) begin
                    commit  = 1'b1;
                    wr_next = WR_RESP;
                end
            end
            WR_RESP: begin
                S_AXI_AWREADY = !aw_full;
                S_AXI_WREADY  = !w_full;
                S_AXI_BVALID  = 1'b1;
                if (S_AXI_BREADY) wr_next = WR_IDLE;
            end
            default: wr_next = WR_RESET;
        endcase
    end

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            aw_full     <= 1'b0;
            w_full      <= 1'b0;
            aw_idx      <= '0;
            w_data      <= '0;
            w_strb      <= '0;
            S_AXI_BRESP <= RESP_OKAY;
        end else if (commit) begin
            aw_full     <= 1'b0;
            w_full      <= 1'b0;
            S_AXI_BRESP <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_idx  <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) rd_state <= RD_RESET;
        else          rd_state <= rd_next;
    end

    always_comb begin
        rd_next       = rd_state;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        case (rd_state)
            RD_RESET: rd_next = RD_IDLE;
            RD_IDLE: begin
                S_AXI_ARREADY = 1'b1;
                if (S_AXI_ARVALID) rd_next = RD_RESP;
            end
            RD_RESP: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY) rd_next = RD_IDLE;
            end
            default: rd_next = RD_RESET;
        endcase
    end

    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // Read data is sampled from the pre-edge bank, so a same-edge commit is not seen.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= RESP_OKAY;
        end else if (ar_hs) begin
            S_AXI_RDATA <= rd_data;
            S_AXI_RRESP <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    ps_pl_reg_bank #(
        .IDX_WIDTH (IDX_WIDTH),
        .NUM_REGS  (NUM_REGS)
    ) u_bank (
        .clk          (ACLK),
        .rst_n        (ARESETN),
        .wr_en        (commit),
        .wr_idx       (aw_idx),
        .wr_data      (w_data),
        .wr_strb      (w_strb),
        .wr_ok        (wr_ok),
        .rd_idx       (S_AXI_ARADDR[ADDR_WIDTH-1:2]),
        .rd_data      (rd_data),
        .rd_ok        (rd_ok),
        .status_in    (status_in),
        .reg_out      (reg_out),
        .reg_wr_pulse (reg_wr_pulse)
    );

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule
